// File: rtl/bifrost_pkg.sv
// Shared constants for the bifrost glue logic: register map of the interrupt
// controller, the "nothing pending" vector code and the channel limit.
package bifrost_pkg;

  localparam logic [1:0] IRQ_REG_STATUS = 2'd0;
  localparam logic [1:0] IRQ_REG_MASK   = 2'd1;
  localparam logic [1:0] IRQ_REG_MODE   = 2'd2;
  localparam logic [1:0] IRQ_REG_VECTOR = 2'd3;

  localparam logic [7:0] IRQ_VECTOR_NONE = 8'h80;

  localparam int IRQ_MAX_CHANNELS = 8;

  // Lowest-numbered set bit wins; an empty source set yields IRQ_VECTOR_NONE.
  function automatic logic [7:0] irq_vector(input logic [7:0] src);
    logic [7:0] vec;
    vec = IRQ_VECTOR_NONE;
    for (int i = IRQ_MAX_CHANNELS - 1; i >= 0; i--) begin
      if (src[i]) vec = {5'b0, 3'(i)};
    end
    return vec;
  endfunction

endpackage

// File: rtl/bifrost_irq_sync.sv
// One interrupt input: multi-flop synchroniser (idle high) followed by a
// history flop so the parent can see the cycle on which the request appears.
module bifrost_irq_sync
  import bifrost_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic irq_n,
  output logic req,
  output logic rise_req
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   req_d;

  // Shift the raw line through the synchroniser and remember last cycle's req.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync  <= '1;
      req_d <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], irq_n};
      req_d <= req;
    end
  end

  assign req      = ~sync[SYNC_STAGES-1];
  assign rise_req = req & ~req_d;

endmodule

// File: rtl/bifrost_irq.sv
// bifrost interrupt controller: synchronises active-low peripheral lines,
// latches (edge) or follows (level) them per channel, masks them and drives a
// single active-low IRQ plus a priority vector register for the ISR.
// Optional macro BIFROST_IRQ_NMI_EN turns the top channel into an edge-only
// NMI source with its own nmi_out_n output.
module bifrost_irq
  import bifrost_pkg::*;
#(
  parameter int CHANNELS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] irq_n,
  input  logic                cs,
  input  logic [1:0]          addr,
  input  logic                rw,
  input  logic [7:0]          wdata,
  output logic [7:0]          rdata,
  output logic                irq_out_n
`ifdef BIFROST_IRQ_NMI_EN
  ,
  output logic                nmi_out_n
`endif
);

`ifdef BIFROST_IRQ_NMI_EN
  localparam logic [CHANNELS-1:0] NMI_BIT = CHANNELS'(1) << (CHANNELS - 1);
`else
  localparam logic [CHANNELS-1:0] NMI_BIT = '0;
`endif

  logic [CHANNELS-1:0] req, rise_req;
  logic [CHANNELS-1:0] pending, pending_next;
  logic [CHANNELS-1:0] mask, mode;
  logic [CHANNELS-1:0] mode_wr, mode_chg, w1c, irq_src;
  logic [7:0]          pending8, mask8, mode8, src8;
  logic                wr;
  logic                unused_wdata;

  assign wr           = cs & ~rw;
  assign unused_wdata = ^wdata;

  // The NMI channel's mode bit is pinned to edge and cannot be written.
  assign mode_wr  = (wdata[CHANNELS-1:0] & ~NMI_BIT) | NMI_BIT;
  assign mode_chg = (wr && addr == IRQ_REG_MODE)   ? (mode ^ mode_wr)      : '0;
  assign w1c      = (wr && addr == IRQ_REG_STATUS) ? wdata[CHANNELS-1:0]   : '0;
  assign irq_src  = pending & mask & ~NMI_BIT;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      bifrost_irq_sync #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .irq_n    (irq_n[gi]),
        .req      (req[gi]),
        .rise_req (rise_req[gi])
      );

      // A mode change discards stale state; level follows req; in edge mode
      // a new edge beats a simultaneous W1C.
      assign pending_next[gi] = mode_chg[gi] ? 1'b0 :
                                !mode[gi]    ? req[gi] :
                                rise_req[gi] ? 1'b1 :
                                w1c[gi]      ? 1'b0 : pending[gi];
    end
  endgenerate

  // Register file and the registered aggregate IRQ output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending   <= '0;
      mask      <= '0;
      mode      <= NMI_BIT;
      irq_out_n <= 1'b1;
    end else begin
      pending   <= pending_next;
      irq_out_n <= ~|irq_src;
      if (wr && addr == IRQ_REG_MASK) mask <= wdata[CHANNELS-1:0];
      if (wr && addr == IRQ_REG_MODE) mode <= mode_wr;
    end
  end

`ifdef BIFROST_IRQ_NMI_EN
  // NMI output follows the masked pending state of the top channel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) nmi_out_n <= 1'b1;
    else        nmi_out_n <= ~(pending[CHANNELS-1] & mask[CHANNELS-1]);
  end
`endif

  // Zero-extend the implemented channels to the 8-bit bus view.
  always_comb begin
    pending8 = '0;
    mask8    = '0;
    mode8    = '0;
    src8     = '0;
    pending8[CHANNELS-1:0] = pending;
    mask8[CHANNELS-1:0]    = mask;
    mode8[CHANNELS-1:0]    = mode;
    src8[CHANNELS-1:0]     = irq_src;
  end

  // Side-effect-free read mux; the bus reads zero when not selected.
  always_comb begin
    rdata = 8'h00;
    if (cs) begin
      case (addr)
        IRQ_REG_STATUS: rdata = pending8;
        IRQ_REG_MASK:   rdata = mask8;
        IRQ_REG_MODE:   rdata = mode8;
        default:        rdata = irq_vector(src8);
      endcase
    end
  end

endmodule

// File: tb/tb_bifrost_irq.sv
// Self-checking bench for bifrost_irq (CHANNELS=5, SYNC_STAGES=2).
// Build with BIFROST_IRQ_NMI_EN defined to also exercise the NMI channel.
module tb_bifrost_irq;
  import bifrost_pkg::*;

  localparam int CH = 5;

`ifdef BIFROST_IRQ_NMI_EN
  localparam logic [7:0] NMI_M = 8'h10;
`else
  localparam logic [7:0] NMI_M = 8'h00;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [CH-1:0] irq_n = '1;
  logic          cs    = 1'b0;
  logic          rw    = 1'b1;
  logic [1:0]    addr  = 2'd0;
  logic [7:0]    wdata = 8'h00;
  logic [7:0]    rdata;
  logic          irq_out_n;
`ifdef BIFROST_IRQ_NMI_EN
  logic          nmi_out_n;
`endif

  bifrost_irq #(.CHANNELS(CH), .SYNC_STAGES(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .irq_n     (irq_n),
    .cs        (cs),
    .addr      (addr),
    .rw        (rw),
    .wdata     (wdata),
    .rdata     (rdata),
    .irq_out_n (irq_out_n)
`ifdef BIFROST_IRQ_NMI_EN
    ,
    .nmi_out_n (nmi_out_n)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          cs;
    logic          rw;
    logic [1:0]    addr;
    logic [7:0]    wdata;
    logic [CH-1:0] irq_n;
    logic          chk_rd;
    logic [7:0]    exp_rd;
    int            exp_irq;   // 0/1 expected, 2 = not checked
  } vec_t;

  typedef struct {
    int         idx;
    logic       chk_rd;
    logic [7:0] exp_rd;
    int         exp_irq;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [CH-1:0] n, input logic [7:0] e, input int ei);
    vec_t v;
    v = '{cs: 1'b1, rw: 1'b1, addr: a, wdata: 8'h00, irq_n: n, chk_rd: 1'b1, exp_rd: e, exp_irq: ei};
    vecs.push_back(v);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic [CH-1:0] n, input int ei);
    vec_t v;
    v = '{cs: 1'b1, rw: 1'b0, addr: a, wdata: d, irq_n: n, chk_rd: 1'b0, exp_rd: 8'h00, exp_irq: ei};
    vecs.push_back(v);
  endtask

  task automatic idl(input logic [CH-1:0] n, input int ei);
    vec_t v;
    v = '{cs: 1'b0, rw: 1'b1, addr: 2'd0, wdata: 8'h00, irq_n: n, chk_rd: 1'b1, exp_rd: 8'h00, exp_irq: ei};
    vecs.push_back(v);
  endtask

  // One bus cycle for the hand-written sequences: drive after the falling
  // edge, return 1 time unit later so callers sample mid-phase.
  task automatic cyc(input logic c, input logic r, input logic [1:0] a, input logic [7:0] d);
    @(negedge clock);
    cs = c; rw = r; addr = a; wdata = d;
    #1;
    $display("seq cs=%b rw=%b addr=%0d wdata=%h irq_n=%b rdata=%h irq_out_n=%b",
             cs, rw, addr, wdata, irq_n, rdata, irq_out_n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog step=0 got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clock);
    #1;
    chk("rst_irq_out_n", -1, {7'b0, irq_out_n}, 8'h01);
    chk("rst_rdata_idle", -1, rdata, 8'h00);
    cs = 1'b1; addr = IRQ_REG_VECTOR;
    #1;
    chk("rst_vector", -1, rdata, IRQ_VECTOR_NONE);
    cs = 1'b0; addr = 2'd0;
    @(negedge clock);
    #2 reset = 1'b1;

    // ---------------- vector table ----------------
    // Reset readback
    rd(IRQ_REG_STATUS, 5'h1F, 8'h00, 1);
    rd(IRQ_REG_MASK,   5'h1F, 8'h00, 1);
    rd(IRQ_REG_MODE,   5'h1F, 8'h00 | NMI_M, 1);
    rd(IRQ_REG_VECTOR, 5'h1F, 8'h80, 1);
    idl(5'h1F, 1);
    // Level channel 2: asserts three edges after the input falls
    wr(IRQ_REG_MASK, 8'h04, 5'h1F, 1);
    idl(5'h1B, 1); idl(5'h1B, 1); idl(5'h1B, 1); idl(5'h1B, 1);
    rd(IRQ_REG_VECTOR, 5'h1B, 8'h02, 0);
    rd(IRQ_REG_STATUS, 5'h1B, 8'h04, 0);
    wr(IRQ_REG_STATUS, 8'h04, 5'h1B, 0);
    rd(IRQ_REG_STATUS, 5'h1B, 8'h04, 0);
    rd(IRQ_REG_STATUS, 5'h1F, 8'h04, 0);
    rd(IRQ_REG_STATUS, 5'h1F, 8'h04, 0);
    rd(IRQ_REG_STATUS, 5'h1F, 8'h04, 0);
    rd(IRQ_REG_STATUS, 5'h1F, 8'h00, 0);
    rd(IRQ_REG_VECTOR, 5'h1F, 8'h80, 1);
    // Edge channel 0: latch, hold after release, W1C
    wr(IRQ_REG_MODE, 8'h01, 5'h1F, 1);
    wr(IRQ_REG_MASK, 8'h01, 5'h1F, 1);
    idl(5'h1E, 1); idl(5'h1E, 1); idl(5'h1F, 1);
    rd(IRQ_REG_STATUS, 5'h1F, 8'h01, 1);
    rd(IRQ_REG_STATUS, 5'h1F, 8'h01, 0);
    rd(IRQ_REG_STATUS, 5'h1F, 8'h01, 0);
    wr(IRQ_REG_STATUS, 8'h01, 5'h1F, 0);
    rd(IRQ_REG_STATUS, 5'h1F, 8'h00, 0);
    rd(IRQ_REG_VECTOR, 5'h1F, 8'h80, 1);
    // Channel 1 edge coinciding with a W1C: set wins
    wr(IRQ_REG_MODE, 8'h03, 5'h1F, 1);
    wr(IRQ_REG_MASK, 8'h02, 5'h1F, 1);
    idl(5'h1D, 1); idl(5'h1D, 1);
    wr(IRQ_REG_STATUS, 8'h02, 5'h1D, 1);
    rd(IRQ_REG_STATUS, 5'h1D, 8'h02, 1);
    rd(IRQ_REG_STATUS, 5'h1D, 8'h02, 0);
    wr(IRQ_REG_STATUS, 8'h02, 5'h1D, 0);
    rd(IRQ_REG_STATUS, 5'h1D, 8'h00, 0);
    idl(5'h1F, 1);
    // Priority and masking with channels 1 (edge) and 3 (level)
    wr(IRQ_REG_MASK, 8'h08, 5'h1F, 1);
    idl(5'h15, 1); idl(5'h15, 1); idl(5'h15, 1);
    rd(IRQ_REG_VECTOR, 5'h15, 8'h03, 1);
    rd(IRQ_REG_VECTOR, 5'h15, 8'h03, 0);
    rd(IRQ_REG_STATUS, 5'h15, 8'h0A, 0);
    wr(IRQ_REG_MASK, 8'h0A, 5'h15, 0);
    rd(IRQ_REG_VECTOR, 5'h15, 8'h01, 0);
    wr(IRQ_REG_MASK, 8'h00, 5'h15, 0);
    rd(IRQ_REG_STATUS, 5'h15, 8'h0A, 0);
    rd(IRQ_REG_VECTOR, 5'h15, 8'h80, 1);
    wr(IRQ_REG_MASK, 8'h02, 5'h15, 1);
    rd(IRQ_REG_VECTOR, 5'h15, 8'h01, 1);
    rd(IRQ_REG_VECTOR, 5'h15, 8'h01, 0);
    // Mode change clears only the channel whose mode bit flips
    wr(IRQ_REG_MODE, 8'h01, 5'h15, 0);
    rd(IRQ_REG_STATUS, 5'h15, 8'h08, 0);
    rd(IRQ_REG_STATUS, 5'h15, 8'h0A, 1);
    rd(IRQ_REG_STATUS, 5'h15, 8'h0A, 0);
    // Unimplemented bits and read-only VECTOR
    wr(IRQ_REG_MASK, 8'hFF, 5'h15, 2);
    rd(IRQ_REG_MASK, 5'h15, 8'h1F, 2);
    wr(IRQ_REG_MODE, 8'hFF, 5'h15, 2);
    rd(IRQ_REG_MODE, 5'h15, 8'h1F, 2);
    rd(IRQ_REG_STATUS, 5'h15, 8'h00, 2);
    wr(IRQ_REG_VECTOR, 8'h55, 5'h15, 2);
    rd(IRQ_REG_VECTOR, 5'h15, 8'h80, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t x;
      @(negedge clock);
      cs = vecs[i].cs; rw = vecs[i].rw; addr = vecs[i].addr;
      wdata = vecs[i].wdata; irq_n = vecs[i].irq_n;
      x = '{idx: i, chk_rd: vecs[i].chk_rd, exp_rd: vecs[i].exp_rd, exp_irq: vecs[i].exp_irq};
      sb.push_back(x);
      #1;
      e = sb.pop_front();
      $display("step %0d cs=%b rw=%b addr=%0d wdata=%h irq_n=%b rdata=%h irq_out_n=%b",
               e.idx, cs, rw, addr, wdata, irq_n, rdata, irq_out_n);
      if (e.chk_rd) chk("rdata", e.idx, rdata, e.exp_rd);
      if (e.exp_irq != 2) chk("irq_out_n", e.idx, {7'b0, irq_out_n}, (e.exp_irq == 1) ? 8'h01 : 8'h00);
    end

    // ---------------- asynchronous reset mid-operation ----------------
    cyc(1'b1, 1'b0, IRQ_REG_MODE, 8'h00);
    cyc(1'b0, 1'b1, 2'd0, 8'h00);
    cyc(1'b0, 1'b1, 2'd0, 8'h00);
    cyc(1'b1, 1'b1, IRQ_REG_STATUS, 8'h00);
    chk("pre_rst_status", 100, rdata, 8'h0A);
    chk("pre_rst_irq", 100, {7'b0, irq_out_n}, 8'h00);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_irq", 101, {7'b0, irq_out_n}, 8'h01);
    chk("async_rst_status", 101, rdata, 8'h00);
    cyc(1'b1, 1'b1, IRQ_REG_MASK, 8'h00);
    chk("async_rst_mask", 102, rdata, 8'h00);
    cyc(1'b1, 1'b1, IRQ_REG_MODE, 8'h00);
    chk("async_rst_mode", 103, rdata, NMI_M);
    @(negedge clock);
    #2 reset = 1'b1;
    // Lines 1 and 3 were low across reset; level mode picks them up again.
    repeat (4) cyc(1'b1, 1'b1, IRQ_REG_STATUS, 8'h00);
    chk("release_level", 104, rdata, 8'h0A);

`ifdef BIFROST_IRQ_NMI_EN
    // ---------------- NMI channel ----------------
    cyc(1'b1, 1'b0, IRQ_REG_MASK, 8'h10);
    irq_n = 5'h05;
    cyc(1'b0, 1'b1, 2'd0, 8'h00);
    cyc(1'b0, 1'b1, 2'd0, 8'h00);
    irq_n = 5'h15;
    cyc(1'b0, 1'b1, 2'd0, 8'h00);
    cyc(1'b0, 1'b1, 2'd0, 8'h00);
    cyc(1'b1, 1'b1, IRQ_REG_VECTOR, 8'h00);
    chk("nmi_low", 110, {7'b0, nmi_out_n}, 8'h00);
    chk("nmi_irq_high", 110, {7'b0, irq_out_n}, 8'h01);
    chk("nmi_vector", 110, rdata, 8'h80);
    cyc(1'b1, 1'b0, IRQ_REG_STATUS, 8'h10);
    cyc(1'b0, 1'b1, 2'd0, 8'h00);
    cyc(1'b0, 1'b1, 2'd0, 8'h00);
    chk("nmi_cleared", 111, {7'b0, nmi_out_n}, 8'h01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
